// File: rtl/mem_wbuf_d.sv
// Posted line-write buffer in front of slow data memory.
// Reads are served from the buffer when they hit and go to memory otherwise, with priority over draining.
module mem_wbuf_d #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         up_read,
    input  logic         up_write,
    input  logic [27:0]  up_addr,
    input  logic [127:0] up_wdata,
    output logic [127:0] up_rdata,
    output logic         up_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic         wbuf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} mstate_t;

    logic [27:0]   ent_addr_q [DEPTH];
    logic [127:0]  ent_data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    mstate_t       mstate_q;
    logic          up_ready_q;
    logic [127:0]  up_rdata_q;
    logic          mem_read_q, mem_write_q;
    logic [27:0]   mem_addr_q;
    logic [127:0]  mem_wdata_q;
    logic          rd_pend_q;
    logic [27:0]   rd_addr_q;

    logic          accept, head_busy;
    logic          hit, cmatch;
    logic [PW-1:0] hit_idx, cidx, idx;
    logic          do_rd, rd_hit, rd_miss, do_wr, wr_coal, wr_enq, deq;

    always_comb begin
        // A write is only evaluated when no read is pending, so the engine
        // will start draining the head this cycle whenever it is idle with entries.
        head_busy = (mstate_q == M_WRITE) || (mstate_q == M_IDLE && count_q != '0);
        hit     = 1'b0;
        hit_idx = '0;
        cmatch  = 1'b0;
        cidx    = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && ent_addr_q[idx] == up_addr) begin
                hit     = 1'b1;
                hit_idx = idx;
                if (!(i == 0 && head_busy)) begin
                    cmatch = 1'b1;
                    cidx   = idx;
                end
            end
        end

        accept  = !up_ready_q && !rd_pend_q;
        do_rd   = accept && up_read;
        rd_hit  = do_rd && hit;
        rd_miss = do_rd && !hit;
        do_wr   = accept && up_write && !up_read;
        wr_coal = do_wr && cmatch;
        wr_enq  = do_wr && !cmatch && (count_q != CW'(DEPTH));
        deq     = (mstate_q == M_WRITE) && mem_ready;
        count_d = count_q + CW'(wr_enq) - CW'(deq);
    end

    always_ff @(posedge clk) begin
        if (wr_enq) begin
            ent_addr_q[tail_q] <= up_addr;
            ent_data_q[tail_q] <= up_wdata;
        end
        if (wr_coal) begin
            ent_data_q[cidx] <= up_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mstate_q    <= M_IDLE;
            up_ready_q  <= 1'b0;
            up_rdata_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            up_ready_q <= wr_enq || wr_coal || rd_hit;
            if (rd_hit) begin
                up_rdata_q <= ent_data_q[hit_idx];
            end
            if (rd_miss) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= up_addr;
            end
            if (wr_enq) begin
                tail_q <= tail_q + PW'(1);
            end
            count_q <= count_d;

            case (mstate_q)
                M_IDLE: begin
                    if (rd_pend_q || rd_miss) begin
                        mstate_q   <= M_READ;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= rd_pend_q ? rd_addr_q : up_addr;
                    end else if (count_q != '0) begin
                        mstate_q    <= M_WRITE;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= ent_addr_q[head_q];
                        mem_wdata_q <= ent_data_q[head_q];
                    end
                end
                M_WRITE: begin
                    if (mem_ready) begin
                        mstate_q    <= M_IDLE;
                        mem_write_q <= 1'b0;
                        head_q      <= head_q + PW'(1);
                    end
                end
                M_READ: begin
                    if (mem_ready) begin
                        mstate_q   <= M_IDLE;
                        mem_read_q <= 1'b0;
                        up_rdata_q <= mem_rdata;
                        up_ready_q <= 1'b1;
                        rd_pend_q  <= 1'b0;
                    end
                end
                default: mstate_q <= M_IDLE;
            endcase
        end
    end

    assign up_ready   = up_ready_q;
    assign up_rdata   = up_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign wbuf_empty = (count_q == '0) && (mstate_q != M_WRITE);

endmodule

// File: tb/tb_mem_wbuf_d.sv
// Directed bench for mem_wbuf_d: posting, full stall, coalescing/forwarding,
// read priority over drain, and reset during a drain.
module tb_mem_wbuf_d;

    logic         clk;
    logic         proc_reset;
    logic         up_read, up_write;
    logic [27:0]  up_addr;
    logic [127:0] up_wdata;
    logic [127:0] up_rdata;
    logic         up_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         wbuf_empty;

    int total = 0;
    int bad   = 0;

    int n_wr = 0, n_rd = 0, n_wr20 = 0, n_both = 0;
    logic [127:0] wr20_data = '0;
    logic wr_prev = 1'b0, rd_prev = 1'b0;
    int snap_wr, snap_rd;

    mem_wbuf_d #(.DEPTH(4)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .up_read(up_read), .up_write(up_write), .up_addr(up_addr), .up_wdata(up_wdata),
        .up_rdata(up_rdata), .up_ready(up_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .wbuf_empty(wbuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-start monitor, sampled mid-cycle.
    always @(negedge clk) begin
        wr_prev <= mem_write;
        rd_prev <= mem_read;
        if (mem_write && !wr_prev) begin
            n_wr <= n_wr + 1;
            if (mem_addr == 28'h20) begin
                n_wr20    <= n_wr20 + 1;
                wr20_data <= mem_wdata;
            end
        end
        if (mem_read && !rd_prev) n_rd <= n_rd + 1;
        if (mem_read && mem_write) n_both <= n_both + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic [27:0] a, input logic [127:0] d);
        up_write = 1'b1;
        up_read  = 1'b0;
        up_addr  = a;
        up_wdata = d;
    endtask

    initial begin
        logic [27:0]  addrs [5];
        logic [127:0] datas [5];

        proc_reset = 1'b1;
        up_read = 1'b0; up_write = 1'b0; up_addr = '0; up_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick; tick;
        proc_reset = 1'b0;
        chk("rst_up_ready", up_ready, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_up_rdata", up_rdata, 0);
        chk("rst_wbuf_empty", wbuf_empty, 1);

        // Posted write, memory latency 8
        set_wr(28'h0000010, 128'hAAAA_0001);
        tick;
        chk("post_ack", up_ready, 1);
        up_write = 1'b0;
        tick;
        chk("post_mem_write", mem_write, 1);
        chk("post_mem_addr", mem_addr, 28'h10);
        chk("post_mem_wdata", mem_wdata, 128'hAAAA_0001);
        chk("post_not_empty", wbuf_empty, 0);
        repeat (7) tick;
        chk("post_hold", mem_write, 1);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        chk("post_done_write", mem_write, 0);
        chk("post_empty", wbuf_empty, 1);

        // Fill to DEPTH with memory stalled, fifth write must wait
        for (int i = 0; i < 5; i++) begin
            addrs[i] = 28'h100 + 28'(i * 16);
            datas[i] = 128'hB000 + 128'(i);
        end
        set_wr(addrs[0], datas[0]);
        tick;
        chk("full_ack0", up_ready, 1);
        set_wr(addrs[1], datas[1]);
        tick;
        chk("full_gap0", up_ready, 0);
        chk("full_head_addr", mem_addr, addrs[0]);
        tick;
        chk("full_ack1", up_ready, 1);
        set_wr(addrs[2], datas[2]);
        tick;
        tick;
        chk("full_ack2", up_ready, 1);
        set_wr(addrs[3], datas[3]);
        tick;
        tick;
        chk("full_ack3", up_ready, 1);
        set_wr(addrs[4], datas[4]);
        tick;
        chk("full_stall_a", up_ready, 0);
        repeat (4) tick;
        chk("full_stall_b", up_ready, 0);
        chk("full_stall_empty", wbuf_empty, 0);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        chk("full_after_drain_gap", up_ready, 0);
        tick;
        chk("full_ack4", up_ready, 1);
        up_write = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk("full_drain_write", mem_write, 1);
            chk("full_drain_addr", mem_addr, addrs[i]);
            chk("full_drain_data", mem_wdata, datas[i]);
            mem_ready = 1'b1;
            tick;
            mem_ready = 1'b0;
            tick;
        end
        chk("full_empty", wbuf_empty, 1);
        chk("full_write_count", n_wr, 6);

        // Coalesce behind a stalled write, then forward on read
        set_wr(28'h200, 128'hDEAD);
        tick;
        set_wr(28'h20, 128'hBBBB);
        tick;
        chk("coal_busy", mem_addr, 28'h200);
        tick;
        chk("coal_ackB", up_ready, 1);
        set_wr(28'h20, 128'hCCCC);
        tick;
        tick;
        chk("coal_ackC", up_ready, 1);
        up_write = 1'b0;
        up_read  = 1'b1;
        up_addr  = 28'h20;
        tick;
        tick;
        chk("fwd_ready", up_ready, 1);
        chk("fwd_data", up_rdata, 128'hCCCC);
        chk("fwd_no_mem_read", mem_read, 0);
        up_read = 1'b0;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tick;
        chk("coal_write_addr", mem_addr, 28'h20);
        chk("coal_write_data", mem_wdata, 128'hCCCC);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tick;
        chk("coal_empty", wbuf_empty, 1);
        chk("coal_one_write", n_wr20, 1);
        chk("coal_write_val", wr20_data, 128'hCCCC);
        chk("coal_no_reads", n_rd, 0);

        // Read miss overtakes the two queued writes once the head finishes
        set_wr(28'h300, 128'hD0);
        tick;
        set_wr(28'h310, 128'hD1);
        tick;
        tick;
        set_wr(28'h320, 128'hD2);
        tick;
        tick;
        chk("prio_ack2", up_ready, 1);
        up_write = 1'b0;
        up_read  = 1'b1;
        up_addr  = 28'h40;
        tick;
        tick;
        chk("prio_wait_ready", up_ready, 0);
        chk("prio_wait_read", mem_read, 0);
        chk("prio_head_addr", mem_addr, 28'h300);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tick;
        chk("prio_mem_read", mem_read, 1);
        chk("prio_mem_write", mem_write, 0);
        chk("prio_read_addr", mem_addr, 28'h40);
        mem_rdata = 128'h1234_5678_9ABC;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        chk("prio_rd_ready", up_ready, 1);
        chk("prio_rd_data", up_rdata, 128'h1234_5678_9ABC);
        up_read = 1'b0;
        tick;
        chk("prio_next_addr", mem_addr, 28'h310);
        chk("prio_next_write", mem_write, 1);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tick;
        chk("prio_last_addr", mem_addr, 28'h320);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tick;
        chk("prio_empty", wbuf_empty, 1);
        chk("prio_read_count", n_rd, 1);

        // Reset while draining with two entries
        set_wr(28'h400, 128'hE0);
        tick;
        set_wr(28'h410, 128'hE1);
        tick;
        tick;
        up_write = 1'b0;
        tick;
        chk("rstd_in_flight", mem_write, 1);
        chk("rstd_not_empty", wbuf_empty, 0);
        proc_reset = 1'b1;
        tick;
        proc_reset = 1'b0;
        chk("rstd_write_off", mem_write, 0);
        chk("rstd_read_off", mem_read, 0);
        chk("rstd_empty", wbuf_empty, 1);
        tick;
        snap_wr = n_wr;
        snap_rd = n_rd;
        repeat (10) tick;
        chk("rstd_quiet_write", mem_write, 0);
        chk("rstd_quiet_read", mem_read, 0);
        chk("rstd_no_new_wr", n_wr, snap_wr);
        chk("rstd_no_new_rd", n_rd, snap_rd);
        chk("rstd_still_empty", wbuf_empty, 1);
        chk("never_both", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
